term_loopback_cfg: RTL
======================

# term_loopback_cfg

Parametrised north-edge terminal tile for the fabric. It turns `WIRES` incoming southbound-ending wires back onto the northbound-begin wires, using a per-wire mode held in frame-loaded configuration registers. The modes are combinational loop, registered loop, tie-low and test pattern. It also keeps sticky per-wire activity flags for bring-up. Frame strobes and the user clock are forwarded unchanged to the next tile in the column.

## Interface
Parameters:
- `WIRES`, 16: number of looped wires; range 1..256.
- `FrameBitsPerRow`, 32: width of frame data.
- `MaxFramesPerCol`, 20: width of frame strobe bus.
- Derived `ConfigFrames = ceil(2*WIRES/FrameBitsPerRow)`; elaboration error if it exceeds `MaxFramesPerCol`.

Ports:
- `UserCLK`, input, 1: single clock; all state on the rising edge.
- `UserRST`, input, 1: reset, synchronous and active-high.
- `UserCLKo`, output, 1: equals `UserCLK`, buffered.
- `FrameData`, input, `FrameBitsPerRow`: configuration data word.
- `FrameStrobe`, input, `MaxFramesPerCol`: one-hot-per-frame write strobes.
- `FrameStrobe_O`, output, `MaxFramesPerCol`: equals `FrameStrobe`, buffered, combinational.
- `N_END`, input, `WIRES`: wires arriving from the south.
- `S_BEG`, output, `WIRES`: wires driven back south.
- `PatternEn`, input, 1: advances the pattern counter.
- `ClearStatus`, input, 1: clears activity flags.
- `ToggleSeen`, output, `WIRES`: sticky per-wire activity flags.

## Operation
- Config store: a `ConfigFrames x FrameBitsPerRow` register bank.
  - On an edge with `FrameStrobe[k]` high and k < `ConfigFrames`, frame k ← `FrameData`.
  - Several strobes high on the same edge each capture the same `FrameData` into their own frame.
  - Strobes with k ≥ `ConfigFrames` are ignored locally and still forwarded.
- Config vector `cfg` is the concatenation with frame k at bits `[k*FrameBitsPerRow +: FrameBitsPerRow]`. Bits above `2*WIRES` are ignored.
- Mode for wire i is `m = cfg[2i+1:2i]`:
  - 00: `S_BEG[i] = N_END[i]` (combinational; legacy terminal behaviour).
  - 01: `S_BEG[i] = samp[i]`.
  - 10: `S_BEG[i] = 0`.
  - 11: `S_BEG[i] = pat[i]`.
- `samp` (`WIRES` bits): `samp ← N_END` every edge, in every mode.
- `pat` (`WIRES` bits): `pat ← pat + 1` modulo `2^WIRES` on edges with `PatternEn` high; holds otherwise.
- `ToggleSeen[i]` is set on an edge where `N_END[i] != samp[i]`.
  - Cleared on an edge with `ClearStatus` high.
  - Set and clear on the same edge: set wins, so no event is lost.
  - Held otherwise.
- Reset, on an edge with `UserRST` high:
  - Config bank 0, so all wires are in mode 00.
  - `samp` = 0, `pat` = 0, `ToggleSeen` = 0.
  - Reset dominates strobes, `PatternEn` and toggle detection on the same edge.
- Reset has no effect on `FrameStrobe_O` or `UserCLKo`.

## Timing
- Mode 00 has zero latency. Mode 01 has one cycle: `S_BEG` in cycle t+1 equals `N_END` sampled at edge t. Modes 10 and 11 are driven from registers.
- Config written at edge N takes effect in the cycle after edge N; `S_BEG` reflects the new mode combinationally from the register.
- Switching to mode 01 immediately shows the last `samp`, since `samp` runs continuously.
- `pat` wraps from all-ones to 0 with no stall.
- Reset-mid-operation: after the reset edge, all outputs follow mode 00 and `ToggleSeen` = 0. Frames must be reloaded.
- After reset, the first edge with `N_END[i]` = 1 sets `ToggleSeen[i]`, because `samp` = 0.
- `FrameStrobe_O` and `UserCLKo` are purely combinational with no cycle delay.

## Test plan
- **Reset default.** Apply `UserRST` for 2 cycles, then drive `N_END` = 16'hA5C3 → `S_BEG` = 16'hA5C3 in the same cycle; `ToggleSeen` = 16'hA5C3 after the next edge.
- **Mode load and registered path.** `FrameStrobe[0]` = 1 with `FrameData` = 32'h5555_5555 (all mode 01); then `N_END` = 16'h00FF at edge t, 16'hFF00 at edge t+1 → `S_BEG` = 16'h00FF in cycle t+1 and 16'hFF00 in cycle t+2.
- **Mixed modes and pattern.**
  - Setup: `FrameData` = 32'hFFFF_AAAA (wires 0–7 mode 10, wires 8–15 mode 11); `PatternEn` = 1 for 3 edges from reset.
  - Response: `S_BEG` = 16'h0000 on wires 0–7; wires 8–15 show `pat[15:8]` = 0.
  - Force `pat` to 16'hFFFF, one more `PatternEn` edge → `pat` = 0 (wrap).
- **Multi-frame, WIRES = 32.** `ConfigFrames` = 2; pulse `FrameStrobe[1]` only → wires 16–31 change mode and wires 0–15 are unchanged. Strobe `FrameStrobe[5]` → no config change, `FrameStrobe_O[5]` = 1.
- **Status priority.** With `ToggleSeen[3]` = 1, assert `ClearStatus` on the same edge as a new toggle on wire 3 → `ToggleSeen[3]` stays 1. `ClearStatus` with no toggle → 0.
- **Reset mid-operation.** Mode 01 active, assert `UserRST` with `FrameStrobe[0]` high on the same edge → config = 0, `S_BEG` = `N_END` next cycle, `pat` = 0, `ToggleSeen` = 0.

Source files
------------

// File: rtl/term_loopback_cfg.sv
// term_loopback_cfg: north-edge terminal tile looping wires back south with per-wire frame-configured modes
module term_loopback_cfg #(
   parameter int WIRES = 16,
   parameter int FrameBitsPerRow = 32,
   parameter int MaxFramesPerCol = 20
) (
   input  logic                       UserCLK,
   input  logic                       UserRST,
   output logic                       UserCLKo,
   input  logic [FrameBitsPerRow-1:0] FrameData,
   input  logic [MaxFramesPerCol-1:0] FrameStrobe,
   output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
   input  logic [WIRES-1:0]           N_END,
   output logic [WIRES-1:0]           S_BEG,
   input  logic                       PatternEn,
   input  logic                       ClearStatus,
   output logic [WIRES-1:0]           ToggleSeen
);
   localparam int ConfigFrames = (2 * WIRES + FrameBitsPerRow - 1) / FrameBitsPerRow;
   localparam int CfgBits = 2 * WIRES;
   generate
      if (ConfigFrames > MaxFramesPerCol) begin : g_cfg_overflow
         $error("ConfigFrames exceeds MaxFramesPerCol");
      end
   endgenerate
   logic [CfgBits-1:0] cfg;
   logic [WIRES-1:0]   samp;
   logic [WIRES-1:0]   pat;
   assign UserCLKo      = UserCLK;
   assign FrameStrobe_O = FrameStrobe;
   // Only the mode bits of the frame bank are kept; the unused tail of the last frame is never read
   always_ff @(posedge UserCLK)
      if (UserRST)
         cfg <= '0;
      else
         for (int j = 0; j < CfgBits; j++)
            if (FrameStrobe[j / FrameBitsPerRow]) cfg[j] <= FrameData[j % FrameBitsPerRow];
   // Free-running input sample, pattern counter and sticky activity flags (set beats clear)
   always_ff @(posedge UserCLK)
      if (UserRST) begin
         samp       <= '0;
         pat        <= '0;
         ToggleSeen <= '0;
      end else begin
         samp       <= N_END;
         pat        <= PatternEn ? pat + WIRES'(1) : pat;
         ToggleSeen <= (ClearStatus ? '0 : ToggleSeen) | (N_END ^ samp);
      end
   // Per-wire mode mux: 00 pass-through, 01 registered, 10 low, 11 pattern
   always_comb begin
      S_BEG = '0;
      for (int i = 0; i < WIRES; i++)
         S_BEG[i] = cfg[2*i+1] ? (cfg[2*i] & pat[i]) : (cfg[2*i] ? samp[i] : N_END[i]);
   end
endmodule
